// File: rtl/mul_pkg.sv
// Shared constants, beat sideband type and operand-extension helper for mul_pipe.
package mul_pkg;

    localparam int WA_DEF     = 16;
    localparam int WB_DEF     = 16;
    localparam int ACCW_DEF   = 40;
    localparam int STAGES_DEF = 3;
    // Widest value ext_val can handle; must cover WA+WB and ACCW.
    localparam int EXT_MAXW   = 128;

    typedef struct packed {
        logic sgn;
        logic acc_en;
        logic acc_clr;
    } beat_sb_t;

    // Sign- or zero-extends the low w bits of v to the full EXT_MAXW width.
    function automatic logic [EXT_MAXW-1:0] ext_val(input logic [EXT_MAXW-1:0] v,
                                                    input int w,
                                                    input logic sgn);
        logic [EXT_MAXW-1:0] hi;
        hi = {EXT_MAXW{1'b1}} << w;
        if (sgn && v[w-1])
            return v | hi;
        else
            return v & ~hi;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One globally enabled pipeline slice carrying valid, data and beat sideband.
module mul_pipe_stage
    import mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         d_valid,
    input  logic [W-1:0] d_data,
    input  beat_sb_t     d_sb,
    output logic         q_valid,
    output logic [W-1:0] q_data,
    output beat_sb_t     q_sb
);

    // Bubbles load too, so a stage never holds stale data behind a cleared valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_sb    <= '0;
        end else if (en) begin
            q_valid <= d_valid;
            q_data  <= d_data;
            q_sb    <= d_sb;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined signed/unsigned multiplier with multiply-accumulate and valid/ready flow control.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WA     = WA_DEF,
    parameter int WB     = WB_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int ACCW   = ACCW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WA-1:0]      a,
    input  logic [WB-1:0]      b,
    input  logic               sgn,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WA+WB-1:0]   result,
    output logic [ACCW-1:0]    acc
);

    localparam int PW = WA + WB;

    logic            adv;
    logic [PW-1:0]   a_e;
    logic [PW-1:0]   b_e;
    logic [PW-1:0]   prod;
    logic [ACCW-1:0] acc_ext;
    logic [ACCW-1:0] acc_q;

    logic            v  [STAGES+1];
    logic [PW-1:0]   d  [STAGES+1];
    beat_sb_t        sb [STAGES+1];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Extending both operands to the full product width makes the low PW bits
    // of a plain multiply correct for both signed and unsigned beats.
    assign a_e  = PW'(ext_val(EXT_MAXW'(a), WA, sgn));
    assign b_e  = PW'(ext_val(EXT_MAXW'(b), WB, sgn));
    assign prod = a_e * b_e;

    assign v[0]  = in_valid;
    assign d[0]  = prod;
    assign sb[0] = {sgn, acc_en, acc_clr};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        mul_pipe_stage #(.W(PW)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .d_valid (v[i]),
            .d_data  (d[i]),
            .d_sb    (sb[i]),
            .q_valid (v[i+1]),
            .q_data  (d[i+1]),
            .q_sb    (sb[i+1])
        );
    end

    // The accumulator loads on the same edge as the final stage, so acc lines
    // up with the result of the beat that produced it.
    assign acc_ext = ACCW'(ext_val(EXT_MAXW'(d[STAGES-1]), PW, sb[STAGES-1].sgn));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (adv && v[STAGES-1] && sb[STAGES-1].acc_en) begin
            acc_q <= sb[STAGES-1].acc_clr ? acc_ext : acc_q + acc_ext;
        end
    end

    assign out_valid = v[STAGES];
    assign result    = d[STAGES];
    assign acc       = acc_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed scoreboard bench for mul_pipe at default widths and depth.
module tb_mul_pipe;

    localparam int STAGES = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [39:0] acc;

    typedef struct {
        logic [31:0] res;
        logic [39:0] acc;
        int          cyc;
        int          stall;
    } exp_t;

    exp_t        q[$];
    logic [39:0] model_acc;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    logic        accepted;

    logic [15:0] bp_a [10];
    logic [15:0] bp_b [10];
    logic        bp_s [10];
    int          idx;

    always #5 clk = ~clk;

    mul_pipe #(.WA(16), .WB(16), .STAGES(STAGES), .ACCW(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sgn       (sgn),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .acc       (acc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, score outputs just before the edge, then advance.
    task automatic step(input logic v, input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input logic e, input logic c, input logic ordy);
        exp_t               x;
        logic [31:0]        p;
        logic signed [31:0] ps;
        logic [39:0]        ext;
        in_valid  = v;
        a         = av;
        b         = bv;
        sgn       = s;
        acc_en    = e;
        acc_clr   = c;
        out_ready = ordy;
        accepted  = 1'b0;
        #1;
        if (!rst) begin
            if (out_valid) begin
                if (out_ready) begin
                    if (q.size() == 0) begin
                        chk("stale_out", 64'(out_valid), 64'd0);
                    end else begin
                        x = q.pop_front();
                        chk("result", 64'(result), 64'(x.res));
                        chk("acc", 64'(acc), 64'(x.acc));
                        chk("latency", 64'(cyc), 64'(x.cyc + STAGES + stall_cnt - x.stall));
                    end
                end else begin
                    stall_cnt++;
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    if (q.size() > 0) begin
                        chk("stall_acc", 64'(acc), 64'(q[0].acc));
                        chk("stall_result", 64'(result), 64'(q[0].res));
                    end
                end
            end
            if (in_valid && in_ready) begin
                if (s) begin
                    ps  = 32'($signed(av)) * 32'($signed(bv));
                    p   = ps;
                    ext = {{8{p[31]}}, p};
                end else begin
                    p   = 32'(av) * 32'(bv);
                    ext = {8'd0, p};
                end
                if (e) model_acc = c ? ext : model_acc + ext;
                x.res   = p;
                x.acc   = model_acc;
                x.cyc   = cyc;
                x.stall = stall_cnt;
                q.push_back(x);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_acc = '0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_acc", 64'(acc), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Unsigned max operands, no accumulation
        step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(STAGES + 2);

        // Same operands signed then unsigned
        step(1'b1, 16'hFFFF, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(STAGES + 2);

        // MAC chain: 12, 42, 28
        step(1'b1, 16'd3, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 16'd5, 16'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'hFFFE, 16'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(STAGES + 2);

        // Backpressure: 10 beats streamed, consumer stalls for 5 cycles
        for (int i = 0; i < 10; i++) begin
            bp_a[i] = 16'($urandom);
            bp_b[i] = 16'($urandom);
            bp_s[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int s = 0; s < 40 && idx < 10; s++) begin
            step(1'b1, bp_a[idx], bp_b[idx], bp_s[idx], 1'b1, idx == 0, !(s >= 6 && s < 11));
            if (accepted) idx++;
        end
        chk("bp_beats_accepted", 64'(idx), 64'd10);
        idle(STAGES + 2);

        // Accumulator wrap: -1 sign-extended to 40 bits, then +1 unsigned
        step(1'b1, 16'hFFFF, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(STAGES + 2);

        // Reset with beats in flight
        step(1'b1, 16'd100, 16'd200, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd7, 16'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'd11, 16'd13, 1'b0, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_acc", 64'(acc), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        q.delete();
        model_acc = '0;
        idle(STAGES + 3);
        step(1'b1, 16'd9, 16'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(STAGES + 2);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
